md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Execute-stage multiply/divide unit for the 5-stage MIPS pipeline; consumes the E-stage operands and MD control fields latched by the D/E pipeline register.
- Performs mult/multu/div/divu with fixed multi-cycle latency, and supports mthi/mtlo writes and mfhi/mflo reads.
- Exposes Start/Busy so the hazard unit can stall MD-class instructions in D while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, Busy duration in cycles for mult/multu
- DIV_CYCLES, 10, Busy duration in cycles for div/divu

Ports:
- clk  input  1  pipeline clock
- reset  input  1  synchronous, active-high; clears all state
- E_MDControl  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
- E_MDDataOp  input  4  read select: 0 none (E_MDOut=0), 1 mfhi, 2 mflo
- E_RD1  input  32  operand A (rs, forwarded)
- E_RD2  input  32  operand B (rt, forwarded)
- E_Start  output  1  combinational; 1 when E_MDControl is 1..4 and unit not busy
- E_Busy  output  1  registered; high while an operation is in flight
- E_MDOut  output  32  combinational read of committed HI/LO per E_MDDataOp
- E_HI  output  32  committed HI (debug/visibility)
- E_LO  output  32  committed LO

Behaviour:
- Single clock, clk; reset synchronous active-high. On reset: HI=0, LO=0, Busy=0, counter=0, shadow result=0. Start and MDOut follow their inputs, so with Busy=0 they are 0 for E_MDControl=E_MDDataOp=0.
- Start cycle T (E_Start=1): at the edge ending T, compute the result into shadow registers, set counter=N (MULT_CYCLES or DIV_CYCLES), and set Busy=1.
- Mult results: signed mult uses a 64-bit two's-complement product; multu uses a zero-extended product. {HI,LO}=product.
- Div results: LO=quotient and HI=remainder. Signed div truncates toward zero, and the remainder takes the dividend's sign. divu is unsigned.
- Divisor 0: the operation still takes DIV_CYCLES with Busy high, and HI/LO are left unchanged at commit.
- Busy countdown: while Busy=1, counter decrements each edge. At the edge where counter==1, commit shadow to HI/LO and clear Busy.
  - Busy is high for cycles T+1..T+N.
  - The new HI/LO are visible on E_MDOut/E_HI/E_LO from cycle T+N+1.
- mthi/mtlo: when Busy=0, HI (or LO) <= E_RD1 at the edge; the value is visible next cycle.
- Any op code while Busy=1 (1..6) is ignored: no restart, no HI/LO write, and E_Start=0. The hazard unit prevents this case; the unit must still be robust to it.
- A new start is accepted in the cycle immediately after Busy falls.
- mfhi/mflo during Busy return the old committed value. The hazard unit stalls these reads, so this is defined but not relied on.
- Reset asserted mid-operation aborts the operation: Busy=0, HI=LO=0 next cycle, and no late commit.
- Unused op codes (7..15) behave as none. Unused E_MDDataOp codes give E_MDOut=0.

Decomposition:
- The shared constants package holds:
  - MDControl encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO)
  - MDDataOp encodings (MDR_NONE, MDR_HI, MDR_LO)
  - default MULT_CYCLES/DIV_CYCLES
- These are shared with the controller and the D/E register.
- No sub-module is needed. Arithmetic, counter and HI/LO registers live in one module.

Test Plan:
- Reset, then idle -> E_HI=E_LO=0, E_Busy=0, E_MDOut=0.
- mult with RD1=0xFFFFFFFF (-1), RD2=2 at cycle 0 -> E_Start=1 at cycle 0; Busy=1 for cycles 1..5; cycle 6 HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - Repeat as multu -> HI=0x00000001, LO=0xFFFFFFFE.
- div RD1=0xFFFFFFF9 (-7), RD2=2 -> Busy cycles 1..10; cycle 11 LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Repeat as divu 7/2 -> LO=3, HI=1.
- divu with RD2=0 after mthi 0x1234/mtlo 0x5678 -> Busy 10 cycles; then HI=0x1234, LO=0x5678 unchanged.
- Issue mult at cycle 0, then mtlo 0xAAAA and div at cycles 2,3 -> both ignored, E_Start=0 on those cycles; commit at cycle 6 reflects only the mult.
  - A new mult at cycle 6 is accepted (E_Start=1).
- Start div, assert reset at cycle 4 -> cycle 5 Busy=0, HI=LO=0; no commit at cycle 11.

Source files
------------

// File: rtl/md_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_unit_pkg
// Description : Shared encodings for the E-stage multiply/divide unit. These
//               encodings are also used by the controller and the D/E register.
// Revision    : 1.0 - initial release
// ============================================================================
package md_unit_pkg;

  // Operation select carried in E_MDControl
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6
  } md_ctrl_e;

  // Read select carried in E_MDDataOp
  typedef enum logic [3:0] {
    MDR_NONE = 4'd0,
    MDR_HI   = 4'd1,
    MDR_LO   = 4'd2
  } md_rd_e;

  // Default busy durations
  localparam int unsigned C_MULT_CYCLES = 5;
  localparam int unsigned C_DIV_CYCLES  = 10;

  // True for the op codes that launch a multi-cycle operation
  function automatic logic is_arith_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : Execute-stage multiply/divide unit. Results are computed at
//               launch into shadow registers and committed to HI/LO after a
//               fixed busy interval.
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = C_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = C_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDControl,
  input  logic [3:0]  E_MDDataOp,
  input  logic [31:0] E_RD1,
  input  logic [31:0] E_RD2,
  output logic        E_Start,
  output logic        E_Busy,
  output logic [31:0] E_MDOut,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);

  localparam int unsigned C_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int          C_CNT_W      = $clog2(C_MAX_CYCLES + 1);

  logic [C_CNT_W-1:0] r_cnt;
  logic               r_busy;
  logic               r_commit;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_shadow_hi;
  logic [31:0]        r_shadow_lo;

  md_ctrl_e           w_op;
  md_rd_e             w_rd;
  logic               w_start;
  logic [63:0]        w_prod_s;
  logic [63:0]        w_prod_u;
  logic               w_div_zero;
  logic [31:0]        w_divisor;
  logic [31:0]        w_a_mag;
  logic [31:0]        w_b_mag;
  logic [31:0]        w_q_mag;
  logic [31:0]        w_r_mag;
  logic [31:0]        w_quot_s;
  logic [31:0]        w_rem_s;
  logic [31:0]        w_nxt_hi;
  logic [31:0]        w_nxt_lo;
  logic [C_CNT_W-1:0] w_nxt_cnt;
  logic               w_nxt_commit;

  assign w_op    = md_ctrl_e'(E_MDControl);
  assign w_rd    = md_rd_e'(E_MDDataOp);
  assign w_start = is_arith_op(E_MDControl) && !r_busy;

  // Low 64 bits of a product of sign-extended operands give the signed product
  assign w_prod_s = {{32{E_RD1[31]}}, E_RD1} * {{32{E_RD2[31]}}, E_RD2};
  assign w_prod_u = {32'd0, E_RD1} * {32'd0, E_RD2};

  // A zero divisor is replaced so the dividers never see zero; the result is discarded anyway
  assign w_div_zero = (E_RD2 == 32'd0);
  assign w_divisor  = w_div_zero ? 32'd1 : E_RD2;

  // Signed division through magnitudes: quotient truncates toward zero, remainder follows dividend
  assign w_a_mag  = E_RD1[31] ? (32'd0 - E_RD1) : E_RD1;
  assign w_b_mag  = w_divisor[31] ? (32'd0 - w_divisor) : w_divisor;
  assign w_q_mag  = w_a_mag / w_b_mag;
  assign w_r_mag  = w_a_mag % w_b_mag;
  assign w_quot_s = (E_RD1[31] ^ w_divisor[31]) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem_s  = E_RD1[31] ? (32'd0 - w_r_mag) : w_r_mag;

  // Select the shadow result, busy length and commit permission for a launched op
  always_comb begin
    w_nxt_hi     = 32'd0;
    w_nxt_lo     = 32'd0;
    w_nxt_cnt    = C_CNT_W'(MULT_CYCLES);
    w_nxt_commit = 1'b1;
    case (w_op)
      MD_MULT: begin
        w_nxt_hi = w_prod_s[63:32];
        w_nxt_lo = w_prod_s[31:0];
      end
      MD_MULTU: begin
        w_nxt_hi = w_prod_u[63:32];
        w_nxt_lo = w_prod_u[31:0];
      end
      MD_DIV: begin
        w_nxt_hi     = w_rem_s;
        w_nxt_lo     = w_quot_s;
        w_nxt_cnt    = C_CNT_W'(DIV_CYCLES);
        w_nxt_commit = !w_div_zero;
      end
      MD_DIVU: begin
        w_nxt_hi     = E_RD1 % w_divisor;
        w_nxt_lo     = E_RD1 / w_divisor;
        w_nxt_cnt    = C_CNT_W'(DIV_CYCLES);
        w_nxt_commit = !w_div_zero;
      end
      default: begin
        w_nxt_hi = 32'd0;
      end
    endcase
  end

  // Launch, count down, commit, and handle direct HI/LO writes when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_commit    <= 1'b0;
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      r_shadow_hi <= 32'd0;
      r_shadow_lo <= 32'd0;
    end else if (r_busy) begin
      r_cnt <= r_cnt - C_CNT_W'(1);
      if (r_cnt == C_CNT_W'(1)) begin
        r_busy <= 1'b0;
        if (r_commit) begin
          r_hi <= r_shadow_hi;
          r_lo <= r_shadow_lo;
        end
      end
    end else if (w_start) begin
      r_shadow_hi <= w_nxt_hi;
      r_shadow_lo <= w_nxt_lo;
      r_cnt       <= w_nxt_cnt;
      r_commit    <= w_nxt_commit;
      r_busy      <= 1'b1;
    end else if (w_op == MD_MTHI) begin
      r_hi <= E_RD1;
    end else if (w_op == MD_MTLO) begin
      r_lo <= E_RD1;
    end
  end

  // Read port returns committed HI/LO only
  always_comb begin
    E_MDOut = 32'd0;
    case (w_rd)
      MDR_HI:  E_MDOut = r_hi;
      MDR_LO:  E_MDOut = r_lo;
      default: E_MDOut = 32'd0;
    endcase
  end

  assign E_Start = w_start;
  assign E_Busy  = r_busy;
  assign E_HI    = r_hi;
  assign E_LO    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit
// Description : Directed self-checking bench for md_unit with a result
//               scoreboard filled at launch and drained at commit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int unsigned C_MC = 5;
  localparam int unsigned C_DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ctrl;
  logic [3:0]  dop;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        e_start;
  logic        e_busy;
  logic [31:0] e_mdout;
  logic [31:0] e_hi;
  logic [31:0] e_lo;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_unit #(.MULT_CYCLES(C_MC), .DIV_CYCLES(C_DC)) dut (
    .clk        (clk),
    .reset      (reset),
    .E_MDControl(ctrl),
    .E_MDDataOp (dop),
    .E_RD1      (rd1),
    .E_RD2      (rd2),
    .E_Start    (e_start),
    .E_Busy     (e_busy),
    .E_MDOut    (e_mdout),
    .E_HI       (e_hi),
    .E_LO       (e_lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour built from language arithmetic on 64-bit/int types
  function automatic res_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input res_t cur);
    longint          p;
    longint unsigned pu;
    int              q;
    int              r;
    res_t            res;
    res = cur;
    case (c)
      4'd1: begin
        p = longint'($signed(a)) * longint'($signed(b));
        res.hi = p[63:32];
        res.lo = p[31:0];
      end
      4'd2: begin
        pu = {32'd0, a} * {32'd0, b};
        res.hi = pu[63:32];
        res.lo = pu[31:0];
      end
      4'd3: if (b != 0) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        res.hi = r;
        res.lo = q;
      end
      4'd4: if (b != 0) begin
        res.hi = a % b;
        res.lo = a / b;
      end
      default: res = cur;
    endcase
    return res;
  endfunction

  // Drive a launching op in cycle T, check Start, optionally queue its expected result
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input bit push);
    ctrl = c; rd1 = a; rd2 = b; dop = 4'd0;
    #1;
    chk("start_issue", {31'd0, e_start}, 32'd1);
    if (push) sb.push_back(model(c, a, b, '{hi: m_hi, lo: m_lo}));
    step();
    ctrl = 4'd0;
  endtask

  // Compare committed HI/LO and the read port against the oldest queued result
  task automatic pop_check(input string tag);
    res_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_busy_end"}, {31'd0, e_busy}, 32'd0);
      chk({tag, "_hi"}, e_hi, e.hi);
      chk({tag, "_lo"}, e_lo, e.lo);
      dop = 4'd1; #1;
      chk({tag, "_mfhi"}, e_mdout, e.hi);
      dop = 4'd2; #1;
      chk({tag, "_mflo"}, e_mdout, e.lo);
      dop = 4'd0;
      m_hi = e.hi;
      m_lo = e.lo;
    end
  endtask

  // Busy must hold for exactly n cycles after launch, then the result commits
  task automatic finish_op(input int n, input string tag);
    for (int i = 1; i <= n; i++) begin
      #1;
      chk({tag, "_busy"}, {31'd0, e_busy}, 32'd1);
      step();
    end
    #1;
    pop_check(tag);
  endtask

  initial begin
    reset = 1'b1; ctrl = 4'd0; dop = 4'd0; rd1 = 32'd0; rd2 = 32'd0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_hi", e_hi, 32'd0);
    chk("rst_lo", e_lo, 32'd0);
    chk("rst_busy", {31'd0, e_busy}, 32'd0);
    chk("rst_start", {31'd0, e_start}, 32'd0);
    chk("rst_mdout", e_mdout, 32'd0);
    step();

    issue(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
    finish_op(C_MC, "mult");
    dop = 4'd3; #1;
    chk("mdout_unused_sel", e_mdout, 32'd0);
    dop = 4'd0;
    step();

    issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b1);
    finish_op(C_MC, "multu");
    ctrl = 4'd7; rd1 = 32'h1111_1111; #1;
    chk("op7_start", {31'd0, e_start}, 32'd0);
    step();
    ctrl = 4'd0; #1;
    chk("op7_busy", {31'd0, e_busy}, 32'd0);
    chk("op7_hi", e_hi, m_hi);
    step();

    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    finish_op(C_DC, "div");

    issue(4'd4, 32'd7, 32'd2, 1'b1);
    finish_op(C_DC, "divu");

    ctrl = 4'd5; rd1 = 32'h0000_1234; #1;
    chk("mthi_start", {31'd0, e_start}, 32'd0);
    step();
    ctrl = 4'd6; rd1 = 32'h0000_5678; #1;
    chk("mthi_hi", e_hi, 32'h0000_1234);
    step();
    ctrl = 4'd0; #1;
    chk("mtlo_lo", e_lo, 32'h0000_5678);
    m_hi = 32'h0000_1234;
    m_lo = 32'h0000_5678;
    step();

    issue(4'd4, 32'd99, 32'd0, 1'b1);
    finish_op(C_DC, "divzero");

    issue(4'd1, 32'd3, 32'd5, 1'b1);
    #1; chk("ign_busy1", {31'd0, e_busy}, 32'd1); step();
    ctrl = 4'd6; rd1 = 32'h0000_AAAA; #1;
    chk("ign_mtlo_start", {31'd0, e_start}, 32'd0);
    step();
    ctrl = 4'd3; rd1 = 32'd100; rd2 = 32'd7; #1;
    chk("ign_div_start", {31'd0, e_start}, 32'd0);
    step();
    ctrl = 4'd0; dop = 4'd1; #1;
    chk("ign_mfhi_old", e_mdout, 32'h0000_1234);
    chk("ign_busy4", {31'd0, e_busy}, 32'd1);
    step();
    dop = 4'd0; #1;
    chk("ign_busy5", {31'd0, e_busy}, 32'd1);
    step();
    pop_check("ign_mult");
    issue(4'd1, 32'hFFFF_FFFD, 32'd4, 1'b1);
    finish_op(C_MC, "b2b_mult");

    issue(4'd3, 32'd100, 32'd7, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      #1; chk("abort_busy", {31'd0, e_busy}, 32'd1); step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    #1;
    chk("abort_busy_clr", {31'd0, e_busy}, 32'd0);
    chk("abort_hi", e_hi, 32'd0);
    chk("abort_lo", e_lo, 32'd0);
    step();
    for (int i = 6; i <= 12; i++) begin
      #1;
      chk("abort_no_commit_hi", e_hi, 32'd0);
      chk("abort_no_commit_lo", e_lo, 32'd0);
      step();
    end
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
